eyeriss_glb_row_driver: RTL and testbench

- Global-buffer-side end of the PE-row interface.
- Packs queued filter/map/psum words into the 59-bit GLB bus that feeds a PE row.
- Drains finished psums from the row's tail using the read/empty handshake and presents them as a valid/ready result stream.
- Sits between the GLB controller and one PE row; one instance per row.

---
 rtl/eyeriss_glb_pkg.sv | 39 +++
 rtl/glb_cmd_fifo.sv | 54 +++++
 rtl/eyeriss_glb_row_driver.sv | 156 +++++++++++++++
 tb/tb_eyeriss_glb_row_driver.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eyeriss_glb_pkg.sv
// Shared bus layout, command encodings and drain FSM states for the GLB row driver.
// GLB bus is {get_fil, get_map, get_psum, map, filter, id, psum}, MSB first.
package eyeriss_glb_pkg;

   localparam int BUS_W      = 59;
   localparam int DATA_W     = 16;
   localparam int ID_W       = 8;
   localparam int PSUM_LSB   = 0;
   localparam int ID_LSB     = 16;
   localparam int FIL_LSB    = 24;
   localparam int MAP_LSB    = 40;
   localparam int STROBE_LSB = 56;

   // strobe bit positions inside the 3-bit strobe field
   localparam int STB_PSUM = 0;
   localparam int STB_MAP  = 1;
   localparam int STB_FIL  = 2;

   typedef enum logic [1:0] {
      CMD_FIL  = 2'd0,
      CMD_MAP  = 2'd1,
      CMD_PSUM = 2'd2,
      CMD_ILL  = 2'd3
   } cmd_type_e;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_READ = 2'd1,
      R_CAP  = 2'd2,
      R_HOLD = 2'd3
   } drain_state_e;

   typedef struct packed {
      logic [1:0]        typ;
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
   } cmd_t;

endpackage

// File: rtl/glb_cmd_fifo.sv
// Synchronous command FIFO; flags derive from registered pointers only, so a push
// on full is refused even when a pop happens in the same cycle.
module glb_cmd_fifo
   import eyeriss_glb_pkg::*;
#(
   parameter int DEPTH = 16
)(
   input  logic CLK,
   input  logic clr,
   input  logic push_i,
   input  cmd_t wdata_i,
   input  logic pop_i,
   output cmd_t rdata_o,
   output logic full_o,
   output logic empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   cmd_t          mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          do_push, do_pop;

   // extra pointer MSB distinguishes full from empty
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_ff @(posedge CLK or negedge clr) begin
      if (!clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/eyeriss_glb_row_driver.sv
// GLB-side PE-row driver: issues queued commands onto the 59-bit row bus and drains
// tail psums into a valid/ready stream. Optional counters/error flag via GLB_DRV_STATS_EN.
module eyeriss_glb_row_driver
   import eyeriss_glb_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int ROW_NUM = 3
)(
   input  logic               CLK,
   input  logic               clr,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_type,
   input  logic [DATA_W-1:0]  cmd_data,
   input  logic [ID_W-1:0]    cmd_id,
   output logic [BUS_W-1:0]   GLB_BUS,
   input  logic               stall_req,
   output logic               stall,
   input  logic               row_full,
   input  logic               row_empty,
   input  logic [DATA_W-1:0]  row_psum,
   output logic               read,
   output logic               res_valid,
   output logic [DATA_W-1:0]  res_data,
   input  logic               res_ready
`ifdef GLB_DRV_STATS_EN
  ,output logic [15:0]        stat_issued,
   output logic [15:0]        stat_drained,
   output logic               row_err
`endif
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ROW_NUM < 1) begin : g_bad_cfg
      $error("eyeriss_glb_row_driver: DEPTH must be a power of two >= 2 and ROW_NUM >= 1");
   end

   cmd_t fifo_wdata, head;
   logic fifo_full, fifo_empty, issue_go;

   assign fifo_wdata = '{typ: cmd_type, id: cmd_id, data: cmd_data};
   assign cmd_ready  = !fifo_full;
   assign issue_go   = !fifo_empty && !row_full && !stall_req;

   glb_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK     (CLK),
      .clr     (clr),
      .push_i  (cmd_valid),
      .wdata_i (fifo_wdata),
      .pop_i   (issue_go),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   logic [BUS_W-1:0] bus_q, bus_d;
   logic             stall_q;

   // data fields are sticky; only the strobes self-clear every cycle
   always_comb begin
      bus_d = bus_q;
      bus_d[STROBE_LSB +: 3] = 3'b000;
      if (issue_go && head.typ != CMD_ILL) begin
         bus_d[ID_LSB +: ID_W] = head.id;
         case (head.typ)
            CMD_FIL: begin
               bus_d[STROBE_LSB + STB_FIL] = 1'b1;
               bus_d[FIL_LSB +: DATA_W]    = head.data;
            end
            CMD_MAP: begin
               bus_d[STROBE_LSB + STB_MAP] = 1'b1;
               bus_d[MAP_LSB +: DATA_W]    = head.data;
            end
            default: begin
               bus_d[STROBE_LSB + STB_PSUM] = 1'b1;
               bus_d[PSUM_LSB +: DATA_W]    = head.data;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge clr) begin
      if (!clr) begin
         bus_q   <= '0;
         stall_q <= 1'b0;
      end else begin
         bus_q   <= bus_d;
         stall_q <= stall_req;
      end
   end

   assign GLB_BUS = bus_q;
   assign stall   = stall_q;

   drain_state_e      state_q, state_d;
   logic              res_valid_q, res_valid_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;

   // psum arrives one cycle after read, so capture happens in R_CAP
   always_comb begin
      state_d     = state_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      case (state_q)
         R_IDLE: if (!row_empty && !stall_req) state_d = R_READ;
         R_READ: state_d = R_CAP;
         R_CAP: begin
            res_data_d  = row_psum;
            res_valid_d = 1'b1;
            state_d     = R_HOLD;
         end
         R_HOLD: if (res_ready) begin
            res_valid_d = 1'b0;
            state_d     = R_IDLE;
         end
         default: state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge clr) begin
      if (!clr) begin
         state_q     <= R_IDLE;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   assign read      = (state_q == R_READ);
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;

`ifdef GLB_DRV_STATS_EN
   logic [15:0] stat_issued_q, stat_drained_q;
   logic        row_err_q;

   always_ff @(posedge CLK or negedge clr) begin
      if (!clr) begin
         stat_issued_q  <= '0;
         stat_drained_q <= '0;
         row_err_q      <= 1'b0;
      end else begin
         if (issue_go && head.typ != CMD_ILL) stat_issued_q <= stat_issued_q + 16'd1;
         if (res_valid_q && res_ready)        stat_drained_q <= stat_drained_q + 16'd1;
         if (issue_go && head.typ == CMD_ILL) row_err_q <= 1'b1;
      end
   end

   assign stat_issued  = stat_issued_q;
   assign stat_drained = stat_drained_q;
   assign row_err      = row_err_q;
`endif

endmodule

// File: tb/tb_eyeriss_glb_row_driver.sv
// Scoreboarded bench for eyeriss_glb_row_driver: bus words and drained psums are
// predicted at stimulus time and popped when the DUT presents them.
module tb_eyeriss_glb_row_driver;

   logic        CLK = 1'b0;
   logic        clr = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_type = 2'd0;
   logic [15:0] cmd_data = 16'd0;
   logic [7:0]  cmd_id = 8'd0;
   logic [58:0] GLB_BUS;
   logic        stall_req = 1'b0;
   logic        stall;
   logic        row_full = 1'b0;
   logic        row_empty = 1'b1;
   logic [15:0] row_psum = 16'd0;
   logic        read;
   logic        res_valid;
   logic [15:0] res_data;
   logic        res_ready = 1'b0;
`ifdef GLB_DRV_STATS_EN
   logic [15:0] stat_issued, stat_drained;
   logic        row_err;
`endif

   eyeriss_glb_row_driver #(.DEPTH(16), .ROW_NUM(3)) dut (
      .CLK(CLK), .clr(clr),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
      .cmd_data(cmd_data), .cmd_id(cmd_id), .GLB_BUS(GLB_BUS),
      .stall_req(stall_req), .stall(stall),
      .row_full(row_full), .row_empty(row_empty), .row_psum(row_psum), .read(read),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
`ifdef GLB_DRV_STATS_EN
     ,.stat_issued(stat_issued), .stat_drained(stat_drained), .row_err(row_err)
`endif
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad = 0;
   int n_strobe = 0;
   int n_drained = 0;
   logic [58:0] exp_q [$];
   logic [15:0] res_exp_q [$];
   logic [15:0] m_map = 16'd0, m_fil = 16'd0, m_psum = 16'd0;
   logic [7:0]  m_id = 8'd0;
   logic [58:0] mon_bus_e;
   logic [15:0] mon_res_e;

   // reference model of the bus: sticky data fields, one-hot strobe per word
   function automatic logic [58:0] model_issue(input logic [1:0] t, input logic [7:0] id,
                                               input logic [15:0] d);
      logic [2:0] stb;
      stb = 3'b000;
      m_id = id;
      case (t)
         2'd0: begin stb = 3'b100; m_fil = d; end
         2'd1: begin stb = 3'b010; m_map = d; end
         default: begin stb = 3'b001; m_psum = d; end
      endcase
      return {stb, m_map, m_fil, m_id, m_psum};
   endfunction

   // monitor samples two time units after the falling edge, inputs change at +1
   always begin
      @(negedge CLK);
      #2;
      if (clr) begin
         if (GLB_BUS[58:56] != 3'b000) begin
            n_strobe++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL bus_unexpected got=%h expected=none", GLB_BUS);
            end else begin
               mon_bus_e = exp_q.pop_front();
               if (GLB_BUS !== mon_bus_e) begin
                  bad++;
                  $display("FAIL bus_word got=%h expected=%h", GLB_BUS, mon_bus_e);
               end
            end
         end
         if (res_valid && res_ready) begin
            n_drained++;
            total++;
            if (res_exp_q.size() == 0) begin
               bad++;
               $display("FAIL res_unexpected got=%h expected=none", res_data);
            end else begin
               mon_res_e = res_exp_q.pop_front();
               if (res_data !== mon_res_e) begin
                  bad++;
                  $display("FAIL res_data got=%h expected=%h", res_data, mon_res_e);
               end
            end
         end
      end
   end

   task automatic step();
      @(negedge CLK);
      #1;
   endtask

   task automatic push_cmd(input logic [1:0] t, input logic [7:0] id, input logic [15:0] d);
      cmd_valid = 1'b1;
      cmd_type  = t;
      cmd_id    = id;
      cmd_data  = d;
      if (cmd_ready && t != 2'd3) exp_q.push_back(model_issue(t, id, d));
      step();
   endtask

   task automatic test_reset();
      clr = 1'b0;
      step(); step();
      total++; if (GLB_BUS !== 59'd0) begin bad++; $display("FAIL reset_bus got=%h expected=0", GLB_BUS); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b expected=1", cmd_ready); end
      total++; if (read !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL reset_read_stall got=%b%b expected=00", read, stall); end
      total++; if (res_valid !== 1'b0 || res_data !== 16'd0) begin bad++; $display("FAIL reset_res got=%b/%h expected=0/0000", res_valid, res_data); end
      clr = 1'b1;
      step();
   endtask

   task automatic test_filter();
      push_cmd(2'd0, 8'h02, 16'h1234);
      cmd_valid = 1'b0;
      step();
      total++; if (GLB_BUS[58:56] !== 3'b100) begin bad++; $display("FAIL fil_strobe got=%b expected=100", GLB_BUS[58:56]); end
      total++; if (GLB_BUS[39:24] !== 16'h1234) begin bad++; $display("FAIL fil_field got=%h expected=1234", GLB_BUS[39:24]); end
      total++; if (GLB_BUS[23:16] !== 8'h02) begin bad++; $display("FAIL fil_id got=%h expected=02", GLB_BUS[23:16]); end
      step();
      total++; if (GLB_BUS[58:56] !== 3'b000) begin bad++; $display("FAIL fil_strobe_clear got=%b expected=000", GLB_BUS[58:56]); end
   endtask

   task automatic test_back_to_back();
      push_cmd(2'd1, 8'h03, 16'hABCD);
      push_cmd(2'd2, 8'h04, 16'h0007);
      cmd_valid = 1'b0;
      total++; if (GLB_BUS[58:56] !== 3'b010 || GLB_BUS[55:40] !== 16'hABCD) begin bad++; $display("FAIL b2b_map got=%b/%h expected=010/abcd", GLB_BUS[58:56], GLB_BUS[55:40]); end
      step();
      total++; if (GLB_BUS[58:56] !== 3'b001 || GLB_BUS[15:0] !== 16'h0007) begin bad++; $display("FAIL b2b_psum got=%b/%h expected=001/0007", GLB_BUS[58:56], GLB_BUS[15:0]); end
      total++; if (GLB_BUS[55:40] !== 16'hABCD) begin bad++; $display("FAIL b2b_map_hold got=%h expected=abcd", GLB_BUS[55:40]); end
      step();
   endtask

   task automatic test_stall();
      stall_req = 1'b1;
      step();
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL stall_out got=%b expected=1", stall); end
      push_cmd(2'd2, 8'h05, 16'h0077);
      cmd_valid = 1'b0;
      step();
      total++; if (GLB_BUS[58:56] !== 3'b000) begin bad++; $display("FAIL stall_blocks got=%b expected=000", GLB_BUS[58:56]); end
      stall_req = 1'b0;
      step();
      total++; if (stall !== 1'b0 || GLB_BUS[58:56] !== 3'b001) begin bad++; $display("FAIL stall_release got=%b/%b expected=0/001", stall, GLB_BUS[58:56]); end
      step();
   endtask

   task automatic test_full();
      int s0;
      row_full = 1'b1;
      s0 = n_strobe;
      for (int i = 0; i < 16; i++) push_cmd(2'(i % 3), 8'(i), 16'h0100 + 16'(i));
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b expected=0", cmd_ready); end
      push_cmd(2'd0, 8'hFF, 16'hDEAD);
      cmd_valid = 1'b0;
      total++; if (n_strobe != s0) begin bad++; $display("FAIL full_no_strobe got=%0d expected=%0d", n_strobe, s0); end
      row_full = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step();
         total++; if (GLB_BUS[58:56] == 3'b000) begin bad++; $display("FAIL drain_fifo_gap cycle=%0d got=000 expected=strobe", i); end
      end
      step();
      total++; if (GLB_BUS[58:56] !== 3'b000 || exp_q.size() != 0) begin bad++; $display("FAIL full_tail got=%b/%0d expected=000/0", GLB_BUS[58:56], exp_q.size()); end
   endtask

   task automatic test_drain();
      int k;
      int reads;
      row_psum = 16'h00FF; res_ready = 1'b0; row_empty = 1'b0;
      res_exp_q.push_back(16'h00FF);
      k = 0;
      while (!read && k < 20) begin step(); k++; end
      total++; if (!read) begin bad++; $display("FAIL drain_read_timeout got=0 expected=1"); end
      row_empty = 1'b1;
      step();
      total++; if (read !== 1'b0) begin bad++; $display("FAIL read_pulse_width got=%b expected=0", read); end
      k = 0;
      while (!res_valid && k < 10) begin step(); k++; end
      reads = 0;
      for (int i = 0; i < 4; i++) begin
         if (read) reads++;
         total++; if (res_valid !== 1'b1 || res_data !== 16'h00FF) begin bad++; $display("FAIL res_hold got=%b/%h expected=1/00ff", res_valid, res_data); end
         step();
      end
      total++; if (reads != 0) begin bad++; $display("FAIL extra_read got=%0d expected=0", reads); end
      res_ready = 1'b1; row_empty = 1'b0; row_psum = 16'h0A5A;
      res_exp_q.push_back(16'h0A5A);
      step();
      total++; if (res_valid !== 1'b0 || read !== 1'b0) begin bad++; $display("FAIL post_handshake got=%b%b expected=00", res_valid, read); end
      k = 0;
      while (!read && k < 20) begin step(); k++; end
      total++; if (k != 1) begin bad++; $display("FAIL read_gap got=%0d expected=1", k); end
      row_empty = 1'b1;
      k = 0;
      while (n_drained < 2 && k < 20) begin step(); k++; end
      total++; if (n_drained != 2) begin bad++; $display("FAIL second_drain got=%0d expected=2", n_drained); end
      res_ready = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      int k;
      row_full = 1'b1;
      push_cmd(2'd0, 8'h10, 16'h1111);
      push_cmd(2'd1, 8'h11, 16'h2222);
      push_cmd(2'd2, 8'h12, 16'h3333);
      cmd_valid = 1'b0;
      row_psum = 16'h5555; row_empty = 1'b0; res_ready = 1'b0;
      k = 0;
      while (!res_valid && k < 20) begin step(); k++; end
      row_empty = 1'b1; stall_req = 1'b1;
      step();
      total++; if (res_valid !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL pre_reset got=%b%b expected=11", res_valid, stall); end
      #2 clr = 1'b0;
      #1;
      total++; if (GLB_BUS !== 59'd0 || read !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL async_reset_bus got=%h/%b%b expected=0/00", GLB_BUS, read, stall); end
      total++; if (res_valid !== 1'b0 || res_data !== 16'd0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL async_reset_res got=%b/%h/%b expected=0/0000/1", res_valid, res_data, cmd_ready); end
      exp_q.delete(); res_exp_q.delete();
      m_map = 16'd0; m_fil = 16'd0; m_psum = 16'd0; m_id = 8'd0;
      stall_req = 1'b0; row_full = 1'b0;
      step();
      clr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         total++; if (GLB_BUS[58:56] !== 3'b000 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL post_reset got=%b/%b/%b expected=000/1/0", GLB_BUS[58:56], cmd_ready, res_valid); end
      end
   endtask

`ifdef GLB_DRV_STATS_EN
   task automatic test_stats();
      int k;
      int reads;
      clr = 1'b0; step(); clr = 1'b1;
      m_map = 16'd0; m_fil = 16'd0; m_psum = 16'd0; m_id = 8'd0;
      step();
      for (int i = 0; i < 5; i++) push_cmd(2'(i % 3), 8'(i + 32), 16'h0C00 + 16'(i));
      cmd_valid = 1'b0;
      step(); step();
      row_psum = 16'h0042; row_empty = 1'b0; res_ready = 1'b1;
      res_exp_q.push_back(16'h0042); res_exp_q.push_back(16'h0042);
      k = 0; reads = 0;
      while (stat_drained != 16'd2 && k < 40) begin
         if (read) begin reads++; if (reads == 2) row_empty = 1'b1; end
         step(); k++;
      end
      row_empty = 1'b1; res_ready = 1'b0;
      total++; if (row_err !== 1'b0) begin bad++; $display("FAIL row_err_early got=%b expected=0", row_err); end
      push_cmd(2'd3, 8'h77, 16'hBEEF);
      cmd_valid = 1'b0;
      step(); step();
      total++; if (stat_issued !== 16'd5) begin bad++; $display("FAIL stat_issued got=%0d expected=5", stat_issued); end
      total++; if (stat_drained !== 16'd2) begin bad++; $display("FAIL stat_drained got=%0d expected=2", stat_drained); end
      total++; if (row_err !== 1'b1) begin bad++; $display("FAIL row_err got=%b expected=1", row_err); end
   endtask
`endif

   initial begin
      test_reset();
      test_filter();
      test_back_to_back();
      test_stall();
      test_full();
      test_drain();
      test_reset_mid();
`ifdef GLB_DRV_STATS_EN
      test_stats();
`endif
      step(); step();
      total++; if (exp_q.size() != 0 || res_exp_q.size() != 0) begin bad++; $display("FAIL leftover got=%0d/%0d expected=0/0", exp_q.size(), res_exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
